// File: rtl/aes_sub_bytes_engine.sv
// Time-multiplexed AES SubBytes/InvSubBytes engine: SBOXES byte lanes per beat, LANES/SBOXES beats per word.
// Optional abort input enabled by defining AES_SUB_BYTES_ABORT_EN.

package aes_sub_bytes_engine_pkg;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 = product of a^(2^i), i=1..7; maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int unsigned n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] affine_fwd(input logic [7:0] x);
    return x ^ rotl(x, 1) ^ rotl(x, 2) ^ rotl(x, 3) ^ rotl(x, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] affine_inv(input logic [7:0] x);
    return rotl(x, 1) ^ rotl(x, 3) ^ rotl(x, 6) ^ 8'h05;
  endfunction

endpackage

module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  import aes_sub_bytes_engine_pkg::*;

  always_comb y = affine_fwd(gf_inv(a));
endmodule

module aes_inv_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  import aes_sub_bytes_engine_pkg::*;

  always_comb y = gf_inv(affine_inv(a));
endmodule

module aes_sub_bytes_engine #(
  parameter int unsigned LANES  = 16,
  parameter int unsigned SBOXES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_mode,
  input  logic [8*LANES-1:0]   in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*LANES-1:0]   out_data,
  output logic                 busy
`ifdef AES_SUB_BYTES_ABORT_EN
  ,input logic                 abort
`endif
);

  localparam int unsigned BEATS = LANES / SBOXES;
  localparam int unsigned CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned DW    = 8 * LANES;
  localparam int unsigned SW    = 8 * SBOXES;

  if ((LANES % SBOXES) != 0) begin : g_bad_cfg
    $error("aes_sub_bytes_engine: SBOXES must divide LANES");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e          state;
  logic [CW-1:0]   cnt;
  logic            mode_q;
  logic [DW-1:0]   data_q;
  logic [SW-1:0]   beat_in;
  logic [SW-1:0]   beat_out;
  logic            abort_c;

`ifdef AES_SUB_BYTES_ABORT_EN
  assign abort_c = abort;
`else
  assign abort_c = 1'b0;
`endif

  assign in_ready = (state == IDLE) && !abort_c;
  assign busy     = (state != IDLE);

  // Select the captured bytes belonging to the current beat.
  always_comb begin
    beat_in = '0;
    for (int b = 0; b < int'(BEATS); b++) begin
      if (cnt == CW'(b)) beat_in = data_q[b*SW +: SW];
    end
  end

  for (genvar k = 0; k < int'(SBOXES); k++) begin : g_sbox
    logic [7:0] fwd_y;
    logic [7:0] inv_y;

    aes_sbox     u_fwd (.a(beat_in[8*k +: 8]), .y(fwd_y));
    aes_inv_sbox u_inv (.a(beat_in[8*k +: 8]), .y(inv_y));

    assign beat_out[8*k +: 8] = mode_q ? inv_y : fwd_y;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      mode_q    <= 1'b0;
      data_q    <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (abort_c && (state != IDLE)) begin
      state     <= IDLE;
      cnt       <= '0;
      data_q    <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            data_q <= in_data;
            mode_q <= in_mode;
            cnt    <= '0;
            state  <= BUSY;
          end
        end
        BUSY: begin
          for (int b = 0; b < int'(BEATS); b++) begin
            if (cnt == CW'(b)) out_data[b*SW +: SW] <= beat_out;
          end
          // Hold cnt at the last beat; it is re-zeroed on the next accept.
          if (cnt == CW'(BEATS - 1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_sub_bytes_engine.sv
// Self-checking bench for aes_sub_bytes_engine: table-driven word model plus directed vectors.
// Abort scenarios are built when AES_SUB_BYTES_ABORT_EN is defined.
module tb_aes_sub_bytes_engine;

  localparam int BEATS = 4;

  logic         clk;
  logic         rst_n;
  logic         in_valid, in_ready, in_mode;
  logic [127:0] in_data;
  logic         out_valid, out_ready, busy;
  logic [127:0] out_data;
  logic         abort;

  logic         v1, r1, m1, ov1, b1;
  logic [127:0] d1, od1;
  logic         v2, r2, m2, ov2, b2;
  logic [31:0]  d2, od2;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]   fwd_tab [256];
  logic [7:0]   inv_tab [256];

  int           m_phase = 0;
  logic [127:0] m_exp = '0;

  localparam logic [127:0] W_SEQ = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] W_FWD = 128'h76abd7fe2b670130c56f6bf27b777c63;

  aes_sub_bytes_engine #(.LANES(16), .SBOXES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
`ifdef AES_SUB_BYTES_ABORT_EN
    , .abort(abort)
`endif
  );

  aes_sub_bytes_engine #(.LANES(16), .SBOXES(16)) dut_wide (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(r1), .in_mode(m1),
    .in_data(d1), .out_valid(ov1), .out_ready(1'b1), .out_data(od1), .busy(b1)
`ifdef AES_SUB_BYTES_ABORT_EN
    , .abort(1'b0)
`endif
  );

  aes_sub_bytes_engine #(.LANES(4), .SBOXES(1)) dut_narrow (
    .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(r2), .in_mode(m2),
    .in_data(d2), .out_valid(ov2), .out_ready(1'b1), .out_data(od2), .busy(b2)
`ifdef AES_SUB_BYTES_ABORT_EN
    , .abort(1'b0)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // S-box tables from the generator-3 walk over GF(2^8); inverse table by inversion.
  task automatic build_tables();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ 8'(p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ 8'(q << 1);
      q = q ^ 8'(q << 2);
      q = q ^ 8'(q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      fwd_tab[p] = x ^ 8'h63;
    end while (p != 8'h01);
    fwd_tab[0] = 8'h63;
    for (int i = 0; i < 256; i++) inv_tab[fwd_tab[i]] = 8'(i);
  endtask

  function automatic logic [127:0] sub_word(input logic [127:0] w, input logic m);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = m ? inv_tab[w[8*i +: 8]] : fwd_tab[w[8*i +: 8]];
    return r;
  endfunction

  // Cycle-level model: phase 0 idle, 1..BEATS working, BEATS+1 result presented.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) m_phase = 0;
      check("in_ready", 128'(in_ready), 128'((m_phase == 0) && !abort));
      check("busy", 128'(busy), 128'(m_phase != 0));
      check("out_valid", 128'(out_valid), 128'(m_phase == BEATS + 1));
      if (m_phase == BEATS + 1) check("out_data", out_data, m_exp);
      if (rst_n) begin
        if (abort && m_phase != 0) m_phase = 0;
        else if (m_phase == 0) begin
          if (in_valid && !abort) begin
            m_exp   = sub_word(in_data, in_mode);
            m_phase = 1;
          end
        end else if (m_phase <= BEATS) m_phase++;
        else if (out_ready) m_phase = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run0(input logic [127:0] d, input logic m, input logic [127:0] exp,
                      input string name, output logic [127:0] got);
    int k;
    k = 0;
    while (!in_ready && k < 50) begin tick(); k++; end
    in_valid = 1'b1;
    in_data  = d;
    in_mode  = m;
    tick();
    in_valid = 1'b0;
    in_data  = ~d;
    in_mode  = ~m;
    k = 0;
    while (!out_valid && k < 20) begin tick(); k++; end
    check({name, " latency"}, 128'(k), 128'(BEATS));
    check({name, " data"}, out_data, exp);
    got = out_data;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] got, w;
    int k;
    build_tables();
    rst_n = 1'b0; in_valid = 1'b0; in_mode = 1'b0; in_data = '0; out_ready = 1'b1; abort = 1'b0;
    v1 = 1'b0; m1 = 1'b0; d1 = '0; v2 = 1'b0; m2 = 1'b0; d2 = '0;

    check("model fwd 00", 128'(fwd_tab[8'h00]), 128'h63);
    check("model fwd 53", 128'(fwd_tab[8'h53]), 128'hed);
    check("model inv 00", 128'(inv_tab[8'h00]), 128'h52);
    check("model fwd word", sub_word(W_SEQ, 1'b0), W_FWD);

    #1;
    check("reset out_data", out_data, '0);
    check("reset out_valid", 128'(out_valid), 128'(0));
    check("reset in_ready", 128'(in_ready), 128'(1));
    check("reset busy", 128'(busy), 128'(0));
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    run0(W_SEQ, 1'b0, W_FWD, "fwd seq", got);
    run0(W_FWD, 1'b1, W_SEQ, "inv seq", got);
    run0({16{8'h63}}, 1'b1, '0, "inv all63", got);
    run0('0, 1'b1, {16{8'h52}}, "inv all00", got);

    // Backpressure with a second word waiting.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = W_SEQ; in_mode = 1'b0;
    tick();
    in_data = W_FWD; in_mode = 1'b1;
    k = 0;
    while (!out_valid && k < 20) begin tick(); k++; end
    for (int i = 0; i < 10; i++) begin
      check("bp out_valid", 128'(out_valid), 128'(1));
      check("bp in_ready", 128'(in_ready), 128'(0));
      check("bp out_data", out_data, W_FWD);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("bp after hs out_valid", 128'(out_valid), 128'(0));
    check("bp after hs in_ready", 128'(in_ready), 128'(1));
    tick();
    check("bp second accepted", 128'(busy), 128'(1));
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 20) begin tick(); k++; end
    check("bp second data", out_data, W_SEQ);
    tick();

    // Reset with beat 2 pending.
    in_valid = 1'b1; in_data = W_SEQ; in_mode = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("rst out_valid", 128'(out_valid), 128'(0));
    check("rst busy", 128'(busy), 128'(0));
    check("rst in_ready", 128'(in_ready), 128'(1));
    check("rst out_data", out_data, '0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    run0({16{8'h53}}, 1'b0, {16{8'hed}}, "post rst", got);

    // Exhaustive byte round trip through forward then inverse.
    for (int j = 0; j < 16; j++) begin
      for (int i = 0; i < 16; i++) w[8*i +: 8] = 8'(16*j + i);
      run0(w, 1'b0, sub_word(w, 1'b0), "exh fwd", got);
      run0(got, 1'b1, w, "exh inv", got);
    end

    // One beat per word.
    v1 = 1'b1; d1 = W_SEQ; m1 = 1'b0;
    check("wide ready", 128'(r1), 128'(1));
    tick();
    v1 = 1'b0;
    check("wide busy", 128'(b1), 128'(1));
    tick();
    check("wide out_valid", 128'(ov1), 128'(1));
    check("wide data", od1, W_FWD);
    tick();

    // Single S-box, four beats.
    v2 = 1'b1; d2 = 32'h03020100; m2 = 1'b0;
    check("narrow ready", 128'(r2), 128'(1));
    tick();
    v2 = 1'b0;
    k = 0;
    while (!ov2 && k < 20) begin tick(); k++; end
    check("narrow latency", 128'(k), 128'(4));
    check("narrow data", 128'(od2), 128'(32'h7b777c63));
    check("narrow busy", 128'(b2), 128'(1));
    tick();

`ifdef AES_SUB_BYTES_ABORT_EN
    in_valid = 1'b1; in_data = W_SEQ; in_mode = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort busy", 128'(busy), 128'(0));
    check("abort out_data", out_data, '0);
    check("abort in_ready", 128'(in_ready), 128'(1));
    for (int i = 0; i < 6; i++) begin
      check("abort no valid", 128'(out_valid), 128'(0));
      tick();
    end
    abort = 1'b1; in_valid = 1'b1;
    #1;
    check("abort idle in_ready", 128'(in_ready), 128'(0));
    tick();
    check("abort idle no accept", 128'(busy), 128'(0));
    abort = 1'b0; in_valid = 1'b0;
    tick();
    run0(W_SEQ, 1'b0, W_FWD, "after abort", got);
`endif

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
